// File: rtl/intersection_pkg.sv
// Shared types for the intersection sequencer: phase encodings, lamp triples
// and the Moore decode from phase to lamp outputs.
package intersection_pkg;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      CLEAR_A   = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      CLEAR_B   = 3'd5,
      PED_WALK  = 3'd6
   } state_e;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   localparam lamp_t LAMP_RED    = 3'b100;
   localparam lamp_t LAMP_YELLOW = 3'b010;
   localparam lamp_t LAMP_GREEN  = 3'b001;

   typedef struct packed {
      lamp_t ns;
      lamp_t ew;
      logic  walk;
   } lamps_t;

   // Unlisted encodings fall back to all red, which is always a safe aspect.
   function automatic lamps_t decode_lamps(state_e s);
      lamps_t l;
      l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
      case (s)
         NS_GREEN:  l.ns   = LAMP_GREEN;
         NS_YELLOW: l.ns   = LAMP_YELLOW;
         EW_GREEN:  l.ew   = LAMP_GREEN;
         EW_YELLOW: l.ew   = LAMP_YELLOW;
         PED_WALK:  l.walk = 1'b1;
         default:   ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/intersection_controller_timer.sv
// Phase timer: counts enabled cycles and flags the cycle whose count equals
// the current phase limit.
module phase_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] count_q;

   assign done = enable && (count_q == limit);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer with all-red clearance and a latched
// pedestrian request serviced after the east-west clearance phase.
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int unsigned GREEN_CYCLES   = 20,
   parameter int unsigned YELLOW_CYCLES  = 5,
   parameter int unsigned ALL_RED_CYCLES = 2,
   parameter int unsigned WALK_CYCLES    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ped_req,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
   localparam int unsigned MAX_RW  = (ALL_RED_CYCLES > WALK_CYCLES) ? ALL_RED_CYCLES : WALK_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_GY > MAX_RW) ? MAX_GY : MAX_RW;
   localparam int unsigned CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

   localparam logic [CNT_W-1:0] LIM_G = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_Y = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_R = CNT_W'(ALL_RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_W = CNT_W'(WALK_CYCLES - 1);

   state_e           state_q, state_d;
   logic             ped_q, ped_d;
   lamps_t           lamps_q;
   logic [CNT_W-1:0] limit;
   logic             expire;

   always_comb begin
      case (state_q)
         NS_GREEN, EW_GREEN:   limit = LIM_G;
         NS_YELLOW, EW_YELLOW: limit = LIM_Y;
         PED_WALK:             limit = LIM_W;
         default:              limit = LIM_R;
      endcase
   end

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .load   (expire),
      .limit  (limit),
      .done   (expire)
   );

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      state_d = state_q;
      ped_d   = ped_q | ped_req;
      if (expire) begin
         case (state_q)
            NS_GREEN:  state_d = NS_YELLOW;
            NS_YELLOW: state_d = CLEAR_A;
            CLEAR_A:   state_d = EW_GREEN;
            EW_GREEN:  state_d = EW_YELLOW;
            EW_YELLOW: state_d = CLEAR_B;
            CLEAR_B: begin
               if (ped_q) begin
                  state_d = PED_WALK;
                  ped_d   = 1'b0;  // a request in the entry cycle is absorbed
               end else begin
                  state_d = NS_GREEN;
               end
            end
            PED_WALK:  state_d = NS_GREEN;
            default:   state_d = CLEAR_B;
         endcase
      end
   end

   // Lamps are registered from the next state so they move with phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR_B;
         ped_q   <= 1'b0;
         lamps_q <= decode_lamps(CLEAR_B);
      end else begin
         state_q <= state_d;
         ped_q   <= ped_d;
         lamps_q <= decode_lamps(state_d);
      end
   end

   assign ns_red      = lamps_q.ns.red;
   assign ns_yellow   = lamps_q.ns.yellow;
   assign ns_green    = lamps_q.ns.green;
   assign ew_red      = lamps_q.ew.red;
   assign ew_yellow   = lamps_q.ew.yellow;
   assign ew_green    = lamps_q.ew.green;
   assign walk        = lamps_q.walk;
   assign ped_pending = ped_q;
   assign phase       = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: a behavioural model feeds a scoreboard
// every cycle, and scenario tasks check timing-specific properties inline.
module tb_intersection_controller;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       ped_req;
   logic       ns_red, ns_yellow, ns_green;
   logic       ew_red, ew_yellow, ew_green;
   logic       walk;
   logic       ped_pending;
   logic [2:0] phase;

   int total = 0;
   int bad   = 0;

   logic [10:0] sb[$];

   int m_state;
   int m_cnt;
   bit m_ped;

   intersection_controller dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .ped_req     (ped_req),
      .ns_red      (ns_red),
      .ns_yellow   (ns_yellow),
      .ns_green    (ns_green),
      .ew_red      (ew_red),
      .ew_yellow   (ew_yellow),
      .ew_green    (ew_green),
      .walk        (walk),
      .ped_pending (ped_pending),
      .phase       (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dur(int s);
      case (s)
         0, 3:    return 20;
         1, 4:    return 5;
         6:       return 10;
         default: return 2;
      endcase
   endfunction

   // {ns r,y,g, ew r,y,g, walk, ped_pending, phase}
   function automatic logic [10:0] exp_vec(int s, bit p);
      logic [6:0] l;
      logic [2:0] ph;
      case (s)
         0:       l = 7'b001_100_0;
         1:       l = 7'b010_100_0;
         3:       l = 7'b100_001_0;
         4:       l = 7'b100_010_0;
         6:       l = 7'b100_100_1;
         default: l = 7'b100_100_0;
      endcase
      ph = s[2:0];
      return {l, p, ph};
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit req);
      int nxt;
      bit pn;
      if (rst) begin
         m_state = 5;
         m_cnt   = 0;
         m_ped   = 1'b0;
      end else begin
         pn = m_ped | req;
         if (en && m_cnt == dur(m_state) - 1) begin
            case (m_state)
               0: nxt = 1;
               1: nxt = 2;
               2: nxt = 3;
               3: nxt = 4;
               4: nxt = 5;
               5: begin
                  if (m_ped) begin
                     nxt = 6;
                     pn  = 1'b0;
                  end else begin
                     nxt = 0;
                  end
               end
               default: nxt = 0;
            endcase
            m_state = nxt;
            m_cnt   = 0;
         end else if (en) begin
            m_cnt = m_cnt + 1;
         end
         m_ped = pn;
      end
   endtask

   task automatic step(input bit rst, input bit en, input bit req);
      @(negedge clk);
      reset   = rst;
      enable  = en;
      ped_req = req;
      model_step(rst, en, req);
      sb.push_back(exp_vec(m_state, m_ped));
      @(posedge clk);
      #1;
   endtask

   task automatic advance_until(input int s, input int c);
      int n = 0;
      while (!(m_state == s && m_cnt == c) && n < 300) begin
         step(1'b0, 1'b1, 1'b0);
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL advance_timeout state=%0d cnt=%0d wanted state=%0d cnt=%0d", m_state, m_cnt, s, c);
      end
   endtask

   // Scoreboard plus per-cycle safety invariants.
   initial begin
      logic [10:0] got, exp;
      bit inv_ok;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            got = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                   walk, ped_pending, phase};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL scoreboard t=%0t got=%b required=%b", $time, got, exp);
            end
            inv_ok = ($countones({ns_red, ns_yellow, ns_green}) == 1) &&
                     ($countones({ew_red, ew_yellow, ew_green}) == 1) &&
                     !(!ns_red && !ew_red) &&
                     !(walk && !(ns_red && ew_red));
            total++;
            if (!inv_ok) begin
               bad++;
               $display("FAIL invariant t=%0t ns=%b%b%b ew=%b%b%b walk=%b", $time,
                        ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk);
            end
         end
      end
   end

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      total++;
      if (phase !== 3'd5) begin
         bad++;
         $display("FAIL reset_phase got=%0d required=5", phase);
      end
      total++;
      if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending} !== 8'b100_100_00) begin
         bad++;
         $display("FAIL reset_outputs got=%b%b%b_%b%b%b_%b_%b required=100_100_0_0",
                  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending);
      end
   endtask

   task automatic test_normal_cycle();
      int r1 = -1, r2 = -1, glen = 0, wseen = 0;
      logic prev;
      prev = ns_green;
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (ns_green && !prev) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
         if (ns_green && r1 >= 0 && r2 < 0) glen++;
         if (walk) wseen++;
         prev = ns_green;
      end
      total++;
      if (r1 != 2) begin
         bad++;
         $display("FAIL first_green got=%0d required=2", r1);
      end
      total++;
      if (r2 - r1 != 54) begin
         bad++;
         $display("FAIL period got=%0d required=54", r2 - r1);
      end
      total++;
      if (glen != 20) begin
         bad++;
         $display("FAIL ns_green_len got=%0d required=20", glen);
      end
      total++;
      if (wseen != 0) begin
         bad++;
         $display("FAIL spurious_walk got=%0d required=0", wseen);
      end
   endtask

   task automatic test_ped_walk();
      int wlen = 0, n = 0;
      logic entry_ped = 1'bx;
      bit fin = 1'b0;
      advance_until(3, 5);
      step(1'b0, 1'b1, 1'b1);
      total++;
      if (ped_pending !== 1'b1) begin
         bad++;
         $display("FAIL ped_latch got=%b required=1", ped_pending);
      end
      while (!fin && n < 150) begin
         step(1'b0, 1'b1, 1'b0);
         n++;
         if (walk) begin
            if (wlen == 0) entry_ped = ped_pending;
            wlen++;
         end else if (wlen > 0) begin
            fin = 1'b1;
         end
      end
      total++;
      if (wlen != 10) begin
         bad++;
         $display("FAIL walk_len got=%0d required=10", wlen);
      end
      total++;
      if (entry_ped !== 1'b0) begin
         bad++;
         $display("FAIL ped_clear_on_walk got=%b required=0", entry_ped);
      end
      total++;
      if (phase !== 3'd0 || ns_green !== 1'b1) begin
         bad++;
         $display("FAIL after_walk phase=%0d ns_green=%b required phase=0 ns_green=1", phase, ns_green);
      end
   endtask

   task automatic test_ped_held_edge();
      advance_until(5, 0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      total++;
      if (phase !== 3'd6 || ped_pending !== 1'b0) begin
         bad++;
         $display("FAIL held_edge phase=%0d ped=%b required phase=6 ped=0", phase, ped_pending);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      total++;
      if (ped_pending !== 1'b1 || walk !== 1'b1) begin
         bad++;
         $display("FAIL mid_walk_req ped=%b walk=%b required ped=1 walk=1", ped_pending, walk);
      end
      advance_until(6, 0);
      total++;
      if (walk !== 1'b1 || ped_pending !== 1'b0) begin
         bad++;
         $display("FAIL second_walk walk=%b ped=%b required walk=1 ped=0", walk, ped_pending);
      end
   endtask

   task automatic test_enable_freeze();
      bit frozen_ok = 1'b1;
      int n = 0;
      advance_until(0, 7);
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (phase !== 3'd0 || ns_green !== 1'b1 || ew_red !== 1'b1) frozen_ok = 1'b0;
      end
      total++;
      if (!frozen_ok) begin
         bad++;
         $display("FAIL freeze got=0 required=1 (phase=%0d ns_green=%b)", phase, ns_green);
      end
      while (phase === 3'd0 && n < 40) begin
         step(1'b0, 1'b1, 1'b0);
         n++;
      end
      total++;
      if (n != 13) begin
         bad++;
         $display("FAIL resume_len got=%0d required=13", n);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      advance_until(4, 2);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      total++;
      if (phase !== 3'd5 || ped_pending !== 1'b0 || ns_red !== 1'b1 || ew_red !== 1'b1 || ew_yellow !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset phase=%0d ped=%b ns_red=%b ew_red=%b required 5/0/1/1",
                  phase, ped_pending, ns_red, ew_red);
      end
      while (ns_green !== 1'b1 && n < 10) begin
         step(1'b0, 1'b1, 1'b0);
         n++;
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL restart_green got=%0d required=2", n);
      end
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      ped_req = 1'b0;
      m_state = 5;
      m_cnt   = 0;
      m_ped   = 1'b0;
      test_reset();
      test_normal_cycle();
      test_ped_walk();
      test_ped_held_edge();
      test_enable_freeze();
      test_reset_mid();
      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequencer for a two-approach intersection (north-south, east-west): drives one red/yellow/green triple per approach and a pedestrian WALK signal. It enforces all-red clearance between conflicting greens and services latched pedestrian requests. It sits above the per-light output logic and is the block the traffic-light bench exercises with `enable`.

## Interface
- `GREEN_CYCLES`, 20, enabled cycles per green phase (≥1)
- `YELLOW_CYCLES`, 5, enabled cycles per yellow phase (≥1)
- `ALL_RED_CYCLES`, 2, enabled cycles per all-red clearance (≥1)
- `WALK_CYCLES`, 10, enabled cycles of pedestrian WALK (≥1)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  timer advance; low freezes state and timer
- `ped_req`  in  1  pedestrian request, any-length pulse, sampled every clock
- `ns_red`, `ns_yellow`, `ns_green`  out  1 each  north-south lamps
- `ew_red`, `ew_yellow`, `ew_green`  out  1 each  east-west lamps
- `walk`  out  1  pedestrian WALK
- `ped_pending`  out  1  request latched, not yet serviced
- `phase`  out  3  current state encoding (debug)

## Operation
- States and encodings:
  - `NS_GREEN`=0
  - `NS_YELLOW`=1
  - `CLEAR_A`=2 (all red, next EW)
  - `EW_GREEN`=3
  - `EW_YELLOW`=4
  - `CLEAR_B`=5 (all red, next NS or walk)
  - `PED_WALK`=6 (all red, `walk`=1)
- Transitions, each taken when the phase timer expires:
  - `NS_GREEN`→`NS_YELLOW`→`CLEAR_A`→`EW_GREEN`→`EW_YELLOW`→`CLEAR_B`
  - `CLEAR_B`→`PED_WALK` if `ped_pending`, else →`NS_GREEN`
  - `PED_WALK`→`NS_GREEN`
- Phase timer:
  - Counts 0..N-1 on cycles with `enable`=1, where N is the state's parameter.
  - Expiry is `enable`=1 with count = N-1. On expiry the state changes and the count returns to 0.
  - Each state therefore lasts exactly N enabled cycles.
- `enable`=0: state, count and lamps hold. `ped_req` is still latched.
- Pedestrian latch:
  - Set by `ped_req`=1 in any cycle.
  - Cleared on the `CLEAR_B`→`PED_WALK` transition edge.
  - `ped_req`=1 in that same cycle is absorbed, and the latch ends cleared.
  - `ped_req` during `PED_WALK` sets the latch for the next round.
- Lamps are a Moore decode of the state register:
  - Per approach, exactly one of red/yellow/green is high.
  - A non-red lamp is never high on both approaches at once.
  - `walk`=1 only in `PED_WALK`, with all lamps red.
- Reset value of every output:
  - State `CLEAR_B`, count 0, `ped_pending`=0.
  - `ns_red`=`ew_red`=1, all yellow/green=0, `walk`=0, `phase`=5.
- Reset mid-phase aborts immediately to the reset state and discards any pending request. Reset has priority over `enable` and `ped_req`.

## Timing
- Lamp and `walk` outputs change in the same cycle `phase` changes, one clock after the expiring edge. No combinational path from inputs to lamps.
- `ped_pending` rises the clock after `ped_req` is sampled high.
- After reset release with `enable`=1: `ns_green` rises after exactly `ALL_RED_CYCLES` clocks.
- Full cycle without walk = 2·(G+Y+R) = 54 enabled cycles at defaults. With walk, add `WALK_CYCLES`, giving 64.
- Worst-case request-to-walk latency = 54 enabled cycles (request arriving just after the `CLEAR_B` exit).
- Counter width `CNT_W` = `$clog2` of the largest parameter; a parameter of 1 gives a single-cycle phase.

## Structure
- Package `intersection_pkg` holds:
  - the state enum with the encodings above;
  - a lamp-triple typedef `{red, yellow, green}` and constants `LAMP_RED`/`LAMP_YELLOW`/`LAMP_GREEN`.
- Sub-module `phase_timer`:
  - parameterized width;
  - inputs `clk`, `reset`, `enable`, `load`, `limit`;
  - output `done` (= enable ∧ count==limit). `load` zeroes the count.
- Top holds the FSM, the pedestrian latch and the lamp decode.

## Test plan
- Reset then `enable`=1, defaults: all red for 2 clocks, then NS green 20, NS yellow 5, all red 2, EW green 20, EW yellow 5, all red 2, NS green. The period is 54, and `walk` never rises.
- One-cycle `ped_req` during `EW_GREEN`: `ped_pending`=1 next clock. After `CLEAR_B`, `walk`=1 for 10 clocks with all red, then NS green. `ped_pending` clears on WALK entry.
- `ped_req` held high across the `CLEAR_B`→`PED_WALK` edge only: a single walk occurs and `ped_pending`=0 after. `ped_req` pulsed mid-WALK gives `ped_pending`=1 and a second walk on the next round.
- `enable` low for 30 clocks mid-`NS_GREEN`, at count 7: lamps and `phase` frozen. After re-enable, NS green lasts exactly 13 more clocks.
- `reset` pulsed mid-`EW_YELLOW` with a request pending: the next clock gives all red, `phase`=5, `ped_pending`=0, and the sequence restarts as in the first scenario.
- Every-cycle assertions:
  - one-hot lamp triple per approach;
  - no simultaneous non-red on both approaches;
  - `walk` implies all red.
